// File: rtl/rcb_led_pkg.sv
// rcb_led_pkg -- shared definitions for the LED/status indicator controller.
//   LED_OFF/LED_ON/LED_BLINK/LED_BURST : 2-bit channel mode encoding (cfg_mode)
//   PULSE/GAP                          : burst sub-state encoding
//   LED_DEF_HALF                       : default half-period after reset (0.5 s in 1 us ticks)
//   max2                               : elaboration-time helper for counter sizing
// Optional build macro used by the other files: RCB_LED_PWM_EN.
package rcb_led_pkg;

   typedef enum logic [1:0] {
      LED_OFF   = 2'd0,
      LED_ON    = 2'd1,
      LED_BLINK = 2'd2,
      LED_BURST = 2'd3
   } led_mode_e;

   typedef enum logic {
      PULSE = 1'b0,
      GAP   = 1'b1
   } burst_st_e;

   localparam logic [23:0] LED_DEF_HALF = 24'd500000;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/rcb_led_chan.sv
// rcb_led_chan -- one LED channel: mode/half registers, half-period counter,
// burst sequencer and (with RCB_LED_PWM_EN defined) a duty-cycle gate.
// Ports:
//   clk_100m, rst_n : clock, async active-low reset
//   i_tick          : shared 1 us tick (one cycle wide)
//   i_wr            : config write aimed at this channel (already decoded)
//   i_mode, i_half  : new mode and half-period (half 0 is stored as 1)
//   i_duty          : (RCB_LED_PWM_EN) new duty value
//   i_pwm_nxt       : (RCB_LED_PWM_EN) value the shared PWM counter takes next edge
//   o_led           : LED output, active-high
module rcb_led_chan
   import rcb_led_pkg::*;
#(
   parameter int               CNT_W     = 24,
   parameter logic [CNT_W-1:0] DEF_HALF  = CNT_W'(LED_DEF_HALF),
   parameter int               BURST_LEN = 3,
   parameter int               BURST_GAP = 4
)(
   input  logic             clk_100m,
   input  logic             rst_n,
   input  logic             i_tick,
   input  logic             i_wr,
   input  logic [1:0]       i_mode,
   input  logic [CNT_W-1:0] i_half,
`ifdef RCB_LED_PWM_EN
   input  logic [7:0]       i_duty,
   input  logic [7:0]       i_pwm_nxt,
`endif
   output logic             o_led
);

   // r_seq counts toggles in PULSE and elapsed half-periods in GAP
   localparam int               SEQ_W    = $clog2(max2(2*BURST_LEN, BURST_GAP) + 1);
   localparam logic [SEQ_W-1:0] TGL_LAST = SEQ_W'(2*BURST_LEN - 1);
   localparam logic [SEQ_W-1:0] GAP_LAST = SEQ_W'(BURST_GAP - 1);

   led_mode_e        r_mode;
   burst_st_e        r_bst;
   logic [CNT_W-1:0] r_half;
   logic [CNT_W-1:0] r_cnt;
   logic [SEQ_W-1:0] r_seq;
   logic             r_pat;
   logic             w_wrap;

   assign w_wrap = (r_cnt == r_half - CNT_W'(1));

   // A write takes priority over a coincident tick, so the tick is dropped.
   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         r_mode <= LED_BLINK;
         r_half <= DEF_HALF;
         r_cnt  <= '0;
         r_bst  <= PULSE;
         r_seq  <= '0;
         r_pat  <= 1'b0;
      end else if (i_wr) begin
         r_mode <= led_mode_e'(i_mode);
         r_half <= (i_half == '0) ? CNT_W'(1) : i_half;
         r_cnt  <= '0;
         r_bst  <= PULSE;
         r_seq  <= '0;
         r_pat  <= (led_mode_e'(i_mode) == LED_ON);
      end else if (i_tick && (r_mode == LED_BLINK || r_mode == LED_BURST)) begin
         if (!w_wrap) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end else begin
            r_cnt <= '0;
            if (r_mode == LED_BLINK) begin
               r_pat <= ~r_pat;
            end else if (r_bst == PULSE) begin
               r_pat <= ~r_pat;
               // last toggle of the burst leaves the LED low and opens the gap
               if (r_seq == TGL_LAST) begin
                  r_bst <= GAP;
                  r_seq <= '0;
               end else begin
                  r_seq <= r_seq + SEQ_W'(1);
               end
            end else begin
               if (r_seq == GAP_LAST) begin
                  r_bst <= PULSE;
                  r_seq <= '0;
               end else begin
                  r_seq <= r_seq + SEQ_W'(1);
               end
            end
         end
      end
   end

`ifdef RCB_LED_PWM_EN
   logic [7:0] r_duty;
   logic       r_pwm_on;

   // Gate is computed against next-cycle counter/duty so it lines up with r_pat.
   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         r_duty   <= 8'hFF;
         r_pwm_on <= 1'b1;
      end else begin
         if (i_wr) r_duty <= i_duty;
         r_pwm_on <= (i_pwm_nxt < (i_wr ? i_duty : r_duty));
      end
   end

   assign o_led = r_pat & r_pwm_on;
`else
   assign o_led = r_pat;
`endif

endmodule

// File: rtl/rcb_led_ctrl.sv
// rcb_led_ctrl -- multi-channel LED/status indicator controller.
// Holds the 1 us prescaler, config decode, cfg_err and (optionally) the shared
// PWM counter; per-channel pattern logic lives in rcb_led_chan.
// Build macro: RCB_LED_PWM_EN adds cfg_duty and per-channel duty gating.
// Ports:
//   clk_100m, rst_n : 100 MHz clock, async active-low reset
//   cfg_wr          : one-cycle config strobe
//   cfg_ch          : target channel index
//   cfg_mode        : 0 OFF, 1 ON, 2 BLINK, 3 BURST
//   cfg_half        : half-period in ticks (0 behaves as 1)
//   cfg_duty        : (RCB_LED_PWM_EN) duty, 8'hFF = 255/256 on
//   cfg_err         : one-cycle pulse on a write to a nonexistent channel
//   tick_1us        : prescaler tick, one cycle wide
//   led             : registered LED outputs, active-high
module rcb_led_ctrl
   import rcb_led_pkg::*;
#(
   parameter int               NUM_CH    = 4,
   parameter int               CNT_W     = 24,
   parameter int               PRESCALE  = 100,
   parameter logic [CNT_W-1:0] DEF_HALF  = CNT_W'(LED_DEF_HALF),
   parameter int               BURST_LEN = 3,
   parameter int               BURST_GAP = 4
)(
   input  logic              clk_100m,
   input  logic              rst_n,
   input  logic              cfg_wr,
   input  logic [3:0]        cfg_ch,
   input  logic [1:0]        cfg_mode,
   input  logic [CNT_W-1:0]  cfg_half,
`ifdef RCB_LED_PWM_EN
   input  logic [7:0]        cfg_duty,
`endif
   output logic              cfg_err,
   output logic              tick_1us,
   output logic [NUM_CH-1:0] led
);

   localparam int               PRE_W    = $clog2(PRESCALE);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
   localparam logic [4:0]       NUM_CH_V = 5'(NUM_CH);

   logic [PRE_W-1:0] r_pre;
   logic             r_tick;
   logic             r_err;
   logic             w_ch_ok;

   assign w_ch_ok = ({1'b0, cfg_ch} < NUM_CH_V);

   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         r_pre  <= '0;
         r_tick <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_tick <= (r_pre == PRE_LAST);
         r_pre  <= (r_pre == PRE_LAST) ? '0 : r_pre + PRE_W'(1);
         r_err  <= cfg_wr & ~w_ch_ok;
      end
   end

   assign tick_1us = r_tick;
   assign cfg_err  = r_err;

`ifdef RCB_LED_PWM_EN
   logic [7:0] r_pwm;
   logic [7:0] w_pwm_nxt;

   assign w_pwm_nxt = r_pwm + 8'd1;

   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) r_pwm <= 8'd0;
      else        r_pwm <= w_pwm_nxt;
   end
`endif

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic w_wr;

      assign w_wr = cfg_wr & w_ch_ok & (cfg_ch == 4'(g));

      rcb_led_chan #(
         .CNT_W     (CNT_W),
         .DEF_HALF  (DEF_HALF),
         .BURST_LEN (BURST_LEN),
         .BURST_GAP (BURST_GAP)
      ) u_chan (
         .clk_100m  (clk_100m),
         .rst_n     (rst_n),
         .i_tick    (r_tick),
         .i_wr      (w_wr),
         .i_mode    (cfg_mode),
         .i_half    (cfg_half),
`ifdef RCB_LED_PWM_EN
         .i_duty    (cfg_duty),
         .i_pwm_nxt (w_pwm_nxt),
`endif
         .o_led     (led[g])
      );
   end

endmodule
